// File: rtl/lab4d_readout_seq.sv
// LAB4D readout sequencer: shifts BITS-bit samples off every DOE lane
// and writes one {header, sample} word per lane per sample.
module lab4d_readout_seq #(
  parameter int NUM_LABS = 24,
  parameter int SAMPLES  = 128,
  parameter int BITS     = 12
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   readout_i,
  input  logic [3:0]             readout_header_i,
  input  logic                   test_pattern_i,
  input  logic [3:0]             prescale_i,
  input  logic                   readout_rst_i,
  input  logic [NUM_LABS-1:0]    doe_i,
  input  logic [NUM_LABS-1:0]    fifo_full_i,
  output logic                   ss_incr_o,
  output logic                   srclk_o,
  output logic [16*NUM_LABS-1:0] dat_o,
  output logic                   dat_wr_o,
  output logic                   busy_o,
  output logic                   complete_o
);
  localparam int SW = $clog2(SAMPLES);
  localparam int BW = $clog2(BITS);

  typedef enum logic [2:0] {
    IDLE, SSI, SHIFT, WRITE, DONE
  } state_t;

  state_t state, state_n;
  logic [3:0] div, pre, hdr;
  logic tst, phase, tick, pair_end;
  logic start, wr, last_bit, last_smp;
  logic [SW-1:0] sidx;
  logic [BW-1:0] bidx;
  logic [BITS-1:0] sr [NUM_LABS];
  logic [16*NUM_LABS-1:0] word, dat_q;

  // phase 0 = high tick, phase 1 = low tick
  assign tick     = (div == pre);
  assign pair_end = tick & phase;
  assign last_bit = (bidx == '0);
  assign last_smp = (sidx == SW'(SAMPLES - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    wr      = 1'b0;
    unique case (state)
      IDLE: begin
        if (readout_i) begin
          start   = 1'b1;
          state_n = SSI;
        end
      end
      SSI: begin
        if (pair_end) state_n = SHIFT;
      end
      SHIFT: begin
        if (pair_end && last_bit) state_n = WRITE;
      end
      WRITE: begin
        if (fifo_full_i == '0) begin
          wr      = 1'b1;
          state_n = last_smp ? DONE : SSI;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (readout_rst_i) begin
      state_n = IDLE;
      start   = 1'b0;
      wr      = 1'b0;
    end
  end

  always_comb begin
    word = '0;
    for (int n = 0; n < NUM_LABS; n++) begin
      word[16*n +: 16] = {hdr, tst ?
        BITS'({5'(n), 7'(sidx)}) : sr[n]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div   <= '0;
      pre   <= '0;
      hdr   <= '0;
      tst   <= 1'b0;
      phase <= 1'b0;
      sidx  <= '0;
      bidx  <= '0;
      dat_q <= '0;
    end else if (readout_rst_i) begin
      div   <= '0;
      phase <= 1'b0;
      sidx  <= '0;
      bidx  <= '0;
      dat_q <= '0;
    end else begin
      if (start) begin
        pre   <= prescale_i;
        hdr   <= readout_header_i;
        tst   <= test_pattern_i;
        div   <= '0;
        phase <= 1'b0;
        sidx  <= '0;
      end
      if (state == SSI || state == SHIFT) begin
        div   <= tick ? '0 : div + 4'd1;
        phase <= phase ^ tick;
      end
      if (state == SSI && pair_end)
        bidx <= BW'(BITS - 1);
      if (state == SHIFT && pair_end)
        bidx <= bidx - BW'(1);
      if (wr) begin
        dat_q <= word;
        if (!last_smp) sidx <= sidx + SW'(1);
      end
    end
  end

  // DOE bit is taken on the clk that ends the SRCLK high tick
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int n = 0; n < NUM_LABS; n++) sr[n] <= '0;
    end else if (state == SHIFT && tick && !phase) begin
      for (int n = 0; n < NUM_LABS; n++)
        sr[n] <= {sr[n][BITS-2:0], doe_i[n]};
    end
  end

  assign ss_incr_o  = (state == SSI) & ~phase;
  assign srclk_o    = (state == SHIFT) & ~phase;
  assign busy_o     = (state == SSI) | (state == SHIFT)
                    | (state == WRITE);
  assign complete_o = ~busy_o;
  assign dat_wr_o   = wr;
  assign dat_o      = wr ? word : dat_q;

endmodule

// File: tb/tb_lab4d_readout_seq.sv
// Directed bench for lab4d_readout_seq: full windows, prescale,
// backpressure, aborts and async reset.
module tb_lab4d_readout_seq;
  localparam int NL = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic readout = 1'b0;
  logic tst = 1'b0;
  logic rrst = 1'b0;
  logic [3:0] hdr = '0;
  logic [3:0] pre = '0;
  logic [NL-1:0] doe;
  logic [NL-1:0] full = '0;
  logic ss_incr, srclk, dat_wr, busy, complete;
  logic [16*NL-1:0] dat;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int td = 0;

  int wr_cnt = 0;
  int lane_err = 0;
  int low_cnt = 0;
  int hi_err = 0;
  int ss_err = 0;
  int sr_rise = 0;
  int ss_rise = 0;
  int sr_run = 0;
  int ss_run = 0;
  int quiet_act = 0;
  int exp_run = 1;
  int wr_t [128];
  logic quiet = 1'b0;
  logic [15:0] cap59 = '0;

  logic [3:0] e_hdr = '0;
  logic e_tst = 1'b0;
  logic [11:0] lab_word = '0;
  logic doe_mode = 1'b0;
  logic [NL-1:0] doe_junk = '0;
  int kbit = 0;
  logic lab_bit = 1'b0;
  logic sr_q = 1'b0;

  lab4d_readout_seq dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .readout_i        (readout),
    .readout_header_i (hdr),
    .test_pattern_i   (tst),
    .prescale_i       (pre),
    .readout_rst_i    (rrst),
    .doe_i            (doe),
    .fifo_full_i      (full),
    .ss_incr_o        (ss_incr),
    .srclk_o          (srclk),
    .dat_o            (dat),
    .dat_wr_o         (dat_wr),
    .busy_o           (busy),
    .complete_o       (complete)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // LAB model: bit counter restarts on SS_INCR, advances on SRCLK fall
  always @(negedge clk) begin
    if (ss_incr) kbit = 0;
    else if (sr_q && !srclk) kbit = kbit + 1;
    sr_q = srclk;
    lab_bit = (kbit < 12) ? lab_word[11-kbit] : 1'b0;
  end
  assign doe = doe_mode ? doe_junk : {NL{lab_bit}};

  function automatic logic [15:0] exp_word(input int n, input int s);
    logic [4:0] nn;
    logic [6:0] sv;
    nn = 5'(n);
    sv = 7'(s);
    return {e_hdr, e_tst ? {nn, sv} : lab_word};
  endfunction

  always @(negedge clk) begin
    if (!complete) low_cnt++;
    if (srclk) begin
      if (sr_run == 0) sr_rise++;
      sr_run++;
    end else if (sr_run != 0) begin
      if (sr_run != exp_run) hi_err++;
      sr_run = 0;
    end
    if (ss_incr) begin
      if (ss_run == 0) ss_rise++;
      ss_run++;
    end else if (ss_run != 0) begin
      if (ss_run != exp_run) ss_err++;
      ss_run = 0;
    end
    if (quiet && (dat_wr || srclk || ss_incr || !busy))
      quiet_act++;
    if (dat_wr) begin
      if (wr_cnt < 128) wr_t[wr_cnt] = cyc;
      for (int n = 0; n < NL; n++)
        if (dat[16*n +: 16] != exp_word(n, wr_cnt)) lane_err++;
      if (wr_cnt == 9) cap59 = dat[5*16 +: 16];
      wr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    wr_cnt = 0; lane_err = 0; low_cnt = 0;
    hi_err = 0; ss_err = 0; sr_rise = 0; ss_rise = 0;
    sr_run = 0; ss_run = 0; quiet_act = 0; cap59 = '0;
  endtask

  task automatic start_run(input logic [3:0] h, input logic t,
                           input logic [3:0] p, input logic [11:0] w);
    clr();
    e_hdr = h; e_tst = t; lab_word = w; exp_run = int'(p) + 1;
    hdr = h; tst = t; pre = p; readout = 1'b1;
    step();
    readout = 1'b0;
    t0 = cyc;
    // later changes must not disturb the running window
    hdr = ~h; tst = ~t; pre = 4'(p + 5);
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && !complete; i++) step();
    chk("done_seen", complete, 1);
    td = cyc;
  endtask

  task automatic wait_wr(input int n, input int limit);
    for (int i = 0; i < limit && wr_cnt < n; i++) step();
    chk("wr_seen", wr_cnt >= n, 1);
  endtask

  task automatic chk_gaps(input int per, input int sidx, input int sgap);
    int bad;
    bad = 0;
    chk("first_wr", wr_t[0] - t0, 26 * per);
    for (int i = 1; i < 128; i++)
      if (wr_t[i] - wr_t[i-1] != ((i == sidx) ? sgap : 26 * per + 1))
        bad++;
    chk("gaps", bad, 0);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_ss", ss_incr, 0);
    chk("rst_sr", srclk, 0);
    chk("rst_dat", |dat, 0);
    chk("rst_wr", dat_wr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmp", complete, 1);
    rst_n = 1'b1;
    repeat (2) step();

    start_run(4'h3, 1'b0, 4'd0, 12'hA5C);
    chk("t1_busy", busy, 1);
    chk("t1_cmp", complete, 0);
    wait_done(5000);
    chk("t1_done_t", td - t0, 3456);
    chk("t1_busy_dn", busy, 0);
    chk("t1_wr", wr_cnt, 128);
    chk("t1_lane", lane_err, 0);
    chk("t1_low", low_cnt, 3456);
    chk("t1_sr_rise", sr_rise, 1536);
    chk("t1_ss_rise", ss_rise, 128);
    chk_gaps(1, 0, 0);
    step();
    chk("t1_cmp_aft", complete, 1);
    chk("t1_hold", dat[15:0], 16'h3A5C);

    doe_mode = 1'b1;
    doe_junk = 24'h5AF00F;
    start_run(4'hF, 1'b1, 4'd0, 12'h000);
    wait_done(5000);
    chk("t2_wr", wr_cnt, 128);
    chk("t2_lane", lane_err, 0);
    chk("t2_l5s9", cap59, 16'hF289);
    doe_mode = 1'b0;
    step();

    start_run(4'h6, 1'b0, 4'd3, 12'h1E7);
    wait_done(20000);
    chk("t3_done_t", td - t0, 13440);
    chk("t3_sr_hi", hi_err, 0);
    chk("t3_ss_hi", ss_err, 0);
    chk("t3_sr_rise", sr_rise, 1536);
    chk("t3_ss_rise", ss_rise, 128);
    chk("t3_lane", lane_err, 0);
    chk_gaps(4, 0, 0);
    step();

    start_run(4'h2, 1'b0, 4'd0, 12'h3C3);
    wait_wr(3, 200);
    full[7] = 1'b1;
    repeat (26) step();
    quiet = 1'b1;
    repeat (50) step();
    full = '0;
    quiet = 1'b0;
    wait_done(5000);
    chk("t4_quiet", quiet_act, 0);
    chk("t4_wr", wr_cnt, 128);
    chk("t4_lane", lane_err, 0);
    chk("t4_done_t", td - t0, 3506);
    chk_gaps(1, 3, 77);
    step();

    start_run(4'h1, 1'b1, 4'd0, 12'h000);
    wait_wr(40, 2000);
    repeat (10) step();
    rrst = 1'b1;
    step();
    rrst = 1'b0;
    chk("t5_cmp", complete, 1);
    chk("t5_busy", busy, 0);
    chk("t5_sr", srclk, 0);
    chk("t5_dat", |dat, 0);
    repeat (30) step();
    chk("t5_nowr", wr_cnt, 40);
    start_run(4'h1, 1'b1, 4'd0, 12'h000);
    wait_wr(1, 100);
    chk("t5_first", wr_t[0] - t0, 26);
    chk("t5_lane", lane_err, 0);
    rrst = 1'b1;
    step();
    rrst = 1'b0;
    step();

    start_run(4'h9, 1'b1, 4'd0, 12'h000);
    repeat (40) step();
    readout = 1'b1;
    step();
    readout = 1'b0;
    wait_wr(5, 300);
    chk("t6_w2", wr_t[2] - t0, 80);
    chk("t6_w4", wr_t[4] - wr_t[3], 27);
    chk("t6_lane", lane_err, 0);
    rrst = 1'b1;
    readout = 1'b1;
    step();
    rrst = 1'b0;
    readout = 1'b0;
    step();
    chk("t6_rr_busy", busy, 0);
    rrst = 1'b1;
    readout = 1'b1;
    step();
    rrst = 1'b0;
    readout = 1'b0;
    repeat (3) step();
    chk("t6_rr_idle", busy, 0);
    chk("t6_rr_cmp", complete, 1);

    start_run(4'h9, 1'b0, 4'd0, 12'h0F0);
    repeat (100) step();
    chk("t6_pre_dat", dat[15:0], 16'h90F0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rn_ss", ss_incr, 0);
    chk("t6_rn_sr", srclk, 0);
    chk("t6_rn_dat", |dat, 0);
    chk("t6_rn_wr", dat_wr, 0);
    chk("t6_rn_busy", busy, 0);
    chk("t6_rn_cmp", complete, 1);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("t6_rn_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
